// File: rtl/screen_ctrl.sv
// Screen sequencer (START/GAME/END) with frame-aligned transitions and a registered pixel mux.
// Pixel latency is 1 clock. Requests are latched and committed only on frame_start. There is no backpressure.
module screen_ctrl #(
    parameter int BLINK_FRAMES = 30,
    parameter int END_FRAMES   = 600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        video_on,
    input  logic        btn_start,
    input  logic        game_over,
    input  logic [11:0] start_rgb,
    input  logic [11:0] game_rgb,
    input  logic [11:0] end_rgb,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic [1:0]  screen,
    output logic        game_clr
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_GAME  = 2'd1,
        ST_END   = 2'd2
    } state_t;

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [9:0] END_LAST   = 10'(END_FRAMES - 1);

    state_t      state;
    state_t      next_state;
    logic        pend;
    logic        blink_hidden;
    logic [7:0]  blink_cnt;
    logic [9:0]  end_cnt;
    logic        req;
    logic        commit;
    logic [11:0] pix;

    always_comb begin
        req        = 1'b0;
        next_state = ST_START;
        pix        = 12'h000;
        case (state)
            ST_START: begin
                req        = btn_start;
                next_state = ST_GAME;
                pix        = blink_hidden ? 12'h000 : start_rgb;
            end
            ST_GAME: begin
                req        = game_over;
                next_state = ST_END;
                pix        = game_rgb;
            end
            ST_END: begin
                req        = btn_start | (frame_start & (end_cnt == END_LAST));
                next_state = ST_START;
                pix        = end_rgb;
            end
            default: begin
                req        = 1'b0;
                next_state = ST_START;
                pix        = 12'h000;
            end
        endcase
    end

    // A request raised on a frame_start cycle commits immediately.
    assign commit = frame_start & (pend | req);
    assign screen = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_START;
            pend         <= 1'b0;
            blink_hidden <= 1'b0;
            blink_cnt    <= 8'd0;
            end_cnt      <= 10'd0;
            game_clr     <= 1'b0;
            {r, g, b}    <= 12'h000;
        end else begin
            game_clr  <= 1'b0;
            {r, g, b} <= video_on ? pix : 12'h000;
            if (commit) begin
                state <= next_state;
                pend  <= 1'b0;
                case (next_state)
                    ST_GAME:  game_clr <= 1'b1;
                    ST_END:   end_cnt  <= 10'd0;
                    default: begin
                        blink_cnt    <= 8'd0;
                        blink_hidden <= 1'b0;
                    end
                endcase
            end else begin
                pend <= pend | req;
                if (frame_start && state == ST_START) begin
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt    <= 8'd0;
                        blink_hidden <= ~blink_hidden;
                    end else begin
                        blink_cnt <= blink_cnt + 8'd1;
                    end
                end
                if (frame_start && state == ST_END && end_cnt != END_LAST)
                    end_cnt <= end_cnt + 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_screen_ctrl.sv
// Directed bench for screen_ctrl with BLINK_FRAMES=30 and END_FRAMES=4.
module tb_screen_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        video_on = 1'b0;
    logic        btn_start = 1'b0;
    logic        game_over = 1'b0;
    logic [11:0] start_rgb = 12'h000;
    logic [11:0] game_rgb = 12'h000;
    logic [11:0] end_rgb = 12'h000;
    logic [3:0]  r, g, b;
    logic [1:0]  screen;
    logic        game_clr;

    int total = 0;
    int bad   = 0;

    screen_ctrl #(.BLINK_FRAMES(30), .END_FRAMES(4)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .video_on(video_on),
        .btn_start(btn_start), .game_over(game_over), .start_rgb(start_rgb),
        .game_rgb(game_rgb), .end_rgb(end_rgb), .r(r), .g(g), .b(b),
        .screen(screen), .game_clr(game_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    function automatic logic [15:0] rgb();
        return {4'h0, r, g, b};
    endfunction

    initial begin
        // Reset wins over a coincident frame_start and btn_start.
        frame_start = 1'b1;
        btn_start   = 1'b1;
        tick();
        rst = 1'b0; frame_start = 1'b0; btn_start = 1'b0;
        chk("rst_screen", 16'(screen), 16'd0);
        chk("rst_rgb", rgb(), 16'h000);
        chk("rst_clr", 16'(game_clr), 16'd0);

        video_on  = 1'b1;
        start_rgb = 12'hD5D;
        game_rgb  = 12'h0A0;
        end_rgb   = 12'hF00;
        tick();
        chk("start_rgb", rgb(), 16'hD5D);

        // Mid-frame press waits for the next frame_start.
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        chk("press_wait_scr", 16'(screen), 16'd0);
        chk("press_wait_clr", 16'(game_clr), 16'd0);
        idle(3);
        chk("press_wait2_scr", 16'(screen), 16'd0);
        frame_pulse();
        chk("commit_game_scr", 16'(screen), 16'd1);
        chk("commit_game_clr", 16'(game_clr), 16'd1);
        chk("commit_pre_rgb", rgb(), 16'hD5D);
        tick();
        chk("clr_one_cycle", 16'(game_clr), 16'd0);
        chk("game_rgb", rgb(), 16'h0A0);

        // btn_start is ignored while in GAME.
        idle(3);
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
        idle(3);
        frame_pulse();
        chk("game_btn_scr", 16'(screen), 16'd1);
        chk("game_btn_clr", 16'(game_clr), 16'd0);

        // game_over mid-frame commits only at the next frame_start.
        idle(4);
        game_over = 1'b1;
        tick();
        chk("over_wait_scr", 16'(screen), 16'd1);
        idle(5);
        game_over = 1'b0;
        chk("over_wait2_scr", 16'(screen), 16'd1);
        frame_pulse();
        chk("commit_end_scr", 16'(screen), 16'd2);
        chk("commit_end_rgb", rgb(), 16'h0A0);
        tick();
        chk("end_rgb", rgb(), 16'hF00);
        video_on = 1'b0;
        tick();
        chk("end_blank", rgb(), 16'h000);
        video_on = 1'b1;

        // Automatic return at the 4th frame_start after entry.
        for (int k = 1; k <= 4; k++) begin
            idle(4);
            frame_pulse();
            chk($sformatf("end_auto_f%0d", k), 16'(screen), (k == 4) ? 16'd0 : 16'd2);
        end

        // Blink: frames 0..29 visible, 30..59 hidden, 60 visible again.
        for (int f = 0; f <= 60; f++) begin
            idle(3);
            if (f == 0 || f == 1 || f == 29 || f == 30 || f == 45 || f == 59 || f == 60)
                chk($sformatf("blink_f%0d", f), rgb(), (f < 30 || f >= 60) ? 16'hD5D : 16'h000);
            if (f == 60) begin
                video_on = 1'b0;
                tick();
                chk("start_blank", rgb(), 16'h000);
                video_on = 1'b1;
            end
            frame_pulse();
        end

        // Press coincident with frame_start commits in the same cycle.
        idle(2);
        btn_start   = 1'b1;
        frame_start = 1'b1;
        tick();
        btn_start   = 1'b0;
        frame_start = 1'b0;
        chk("coinc_scr", 16'(screen), 16'd1);
        chk("coinc_clr", 16'(game_clr), 16'd1);

        // Reset in GAME with a pending request.
        tick();
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_scr", 16'(screen), 16'd0);
        chk("mid_rst_rgb", rgb(), 16'h000);
        chk("mid_rst_clr", 16'(game_clr), 16'd0);
        idle(2);
        frame_pulse();
        chk("pend_cleared_scr", 16'(screen), 16'd0);
        chk("pend_cleared_clr", 16'(game_clr), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
